// File: rtl/rcc_pkg.sv
// rcc_pkg: shared capture-FSM state type and default parameters for ripple_count_capture.
package rcc_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} rcc_state_t;
    localparam int RCC_WIDTH         = 4;
    localparam int RCC_SYNC_STAGES   = 2;
    localparam int RCC_STABLE_CYCLES = 2;
    localparam int RCC_WRAP_W        = 8;
endpackage

// File: rtl/rcc_sync_filter.sv
// rcc_sync_filter: per-bit synchronizer plus stability filter for the raw ripple count.
module rcc_sync_filter import rcc_pkg::*; #(
    parameter int WIDTH         = RCC_WIDTH,
    parameter int SYNC_STAGES   = RCC_SYNC_STAGES,
    parameter int STABLE_CYCLES = RCC_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_cnt,
    output logic [WIDTH-1:0] o_sample,
    output logic [WIDTH-1:0] o_stable_q,
    output logic             o_stable_valid,
    output logic             o_update
);
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [SYNC_STAGES-1:0]            r_vld;
    logic [WIDTH-1:0]                  r_last;
    logic [WIDTH-1:0]                  r_stable_q;
    logic [RUN_W-1:0]                  r_run;
    logic                              r_stable_valid;
    logic                              w_vld;
    logic                              w_same;
    logic [RUN_W-1:0]                  w_run_nxt;
    // r_vld tracks refill after reset so the cleared zeros are never taken as samples
    assign w_vld          = r_vld[SYNC_STAGES-1];
    assign o_sample       = r_sync[SYNC_STAGES-1];
    assign w_same         = (r_run != '0) && (o_sample == r_last);
    assign w_run_nxt      = !w_vld ? r_run : !w_same ? RUN_W'(1) : (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
    assign o_update       = w_vld && (w_run_nxt == RUN_MAX) && (!r_stable_valid || o_sample != r_stable_q);
    assign o_stable_q     = r_stable_q;
    assign o_stable_valid = r_stable_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync         <= '0;
            r_vld          <= '0;
            r_last         <= '0;
            r_run          <= '0;
            r_stable_q     <= '0;
            r_stable_valid <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_cnt};
            r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_run  <= w_run_nxt;
            if (w_vld)
                r_last <= o_sample;
            if (o_update) begin
                r_stable_q     <= o_sample;
                r_stable_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ripple_count_capture.sv
// ripple_count_capture: filters a ripple counter, extends it with a wrap count, serves snapshots.
// Define RCC_MONOTONIC_CHECK_EN to add the sticky mon_err output flagging skipped/backward counts.
module ripple_count_capture import rcc_pkg::*; #(
    parameter int WIDTH         = RCC_WIDTH,
    parameter int SYNC_STAGES   = RCC_SYNC_STAGES,
    parameter int STABLE_CYCLES = RCC_STABLE_CYCLES,
    parameter int WRAP_W        = RCC_WRAP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cap_req,
    input  logic              cap_ready,
    output logic              cap_valid,
    output logic [WIDTH-1:0]  cap_value,
    output logic [WRAP_W-1:0] cap_wrap,
    output logic              wrap_pulse,
    output logic              stable_valid
`ifdef RCC_MONOTONIC_CHECK_EN
    ,
    output logic              mon_err
`endif
);
    rcc_state_t        r_state;
    rcc_state_t        w_state_nxt;
    logic [WIDTH-1:0]  w_sample;
    logic [WIDTH-1:0]  w_stable_q;
    logic [WIDTH-1:0]  r_cap_value;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic [WRAP_W-1:0] r_cap_wrap;
    logic              w_update;
    logic              w_stable_valid;
    logic              w_wrap;
    logic              w_latch;
    logic              r_wrap_pulse;

    rcc_sync_filter #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filt (
        .clk            (clk),
        .reset          (reset),
        .i_cnt          (cnt_in),
        .o_sample       (w_sample),
        .o_stable_q     (w_stable_q),
        .o_stable_valid (w_stable_valid),
        .o_update       (w_update)
    );

    assign w_wrap = w_update && w_stable_valid && (w_sample < w_stable_q);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                w_latch     = cap_req && w_stable_valid;
                w_state_nxt = !cap_req ? IDLE : w_stable_valid ? HOLD : WAIT;
            end
            WAIT: begin
                w_latch     = w_stable_valid;
                w_state_nxt = w_stable_valid ? HOLD : WAIT;
            end
            HOLD:    w_state_nxt = cap_ready ? IDLE : HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Snapshot reads the pre-edge registers, so a coincident wrap lands in the next snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap_cnt   <= '0;
            r_wrap_pulse <= 1'b0;
            r_cap_value  <= '0;
            r_cap_wrap   <= '0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_wrap)
                r_wrap_cnt <= r_wrap_cnt + 1'b1;
            if (w_latch) begin
                r_cap_value <= w_stable_q;
                r_cap_wrap  <= r_wrap_cnt;
            end
        end
    end

    assign cap_valid    = (r_state == HOLD);
    assign cap_value    = r_cap_value;
    assign cap_wrap     = r_cap_wrap;
    assign wrap_pulse   = r_wrap_pulse;
    assign stable_valid = w_stable_valid;

`ifdef RCC_MONOTONIC_CHECK_EN
    logic r_mon_err;
    always_ff @(posedge clk) begin
        if (reset)
            r_mon_err <= 1'b0;
        else if (w_update && w_stable_valid && (w_sample != w_stable_q + 1'b1))
            r_mon_err <= 1'b1;
    end
    assign mon_err = r_mon_err;
`endif
endmodule

// File: tb/tb_ripple_count_capture.sv
// tb_ripple_count_capture: vector table, directed corner sequences and random stimulus vs a history-window model.
module tb_ripple_count_capture;
    import rcc_pkg::*;
    localparam int SYNC = 2;
    localparam int STAB = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt_in = 4'h0;
    logic       cap_req = 1'b0;
    logic       cap_ready = 1'b0;
    logic       cap_valid;
    logic [3:0] cap_value;
    logic [7:0] cap_wrap;
    logic       wrap_pulse;
    logic       stable_valid;
`ifdef RCC_MONOTONIC_CHECK_EN
    logic       mon_err;
`endif

    ripple_count_capture dut (
        .clk          (clk),
        .reset        (reset),
        .cnt_in       (cnt_in),
        .cap_req      (cap_req),
        .cap_ready    (cap_ready),
        .cap_valid    (cap_valid),
        .cap_value    (cap_value),
        .cap_wrap     (cap_wrap),
        .wrap_pulse   (wrap_pulse),
        .stable_valid (stable_valid)
`ifdef RCC_MONOTONIC_CHECK_EN
        ,
        .mon_err      (mon_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
    endfunction

    // Reference model: the filter sees cnt_in delayed SYNC edges; a value is accepted once the
    // last STAB seen samples agree and it is new (or nothing has been accepted yet).
    int q_pipe[$];
    int q_seen[$];
    int m_sq, m_sv, m_wc, m_pulse, m_mon, m_state, m_cval, m_cwrap;

    task automatic model_step();
        int s;
        int acc;
        int pre_sq;
        int pre_sv;
        int pre_wc;
        if (reset) begin
            q_pipe.delete();
            q_seen.delete();
            {m_sq, m_sv, m_wc, m_pulse, m_mon, m_state, m_cval, m_cwrap} = '0;
        end else begin
            pre_sq = m_sq;
            pre_sv = m_sv;
            pre_wc = m_wc;
            acc = 0;
            s = 0;
            q_pipe.push_back(int'(cnt_in));
            if (q_pipe.size() > SYNC) begin
                s = q_pipe.pop_front();
                q_seen.push_back(s);
                if (q_seen.size() > STAB)
                    void'(q_seen.pop_front());
                if (q_seen.size() == STAB) begin
                    acc = 1;
                    foreach (q_seen[k])
                        if (q_seen[k] != s)
                            acc = 0;
                    if (m_sv && s == m_sq)
                        acc = 0;
                end
            end
            m_pulse = (acc && m_sv && s < m_sq) ? 1 : 0;
            if (acc && m_sv && s != (m_sq + 1) % 16)
                m_mon = 1;
            if (m_state == 0 && cap_req) begin
                m_state = pre_sv ? 2 : 1;
                if (pre_sv) begin
                    m_cval = pre_sq;
                    m_cwrap = pre_wc;
                end
            end else if (m_state == 1 && pre_sv) begin
                m_state = 2;
                m_cval = pre_sq;
                m_cwrap = pre_wc;
            end else if (m_state == 2 && cap_ready) begin
                m_state = 0;
            end
            if (acc) begin
                m_sq = s;
                m_sv = 1;
            end
            if (m_pulse)
                m_wc = (m_wc + 1) % 256;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("mdl_cap_valid", cap_valid, (m_state == 2) ? 1 : 0);
        check("mdl_cap_value", cap_value, m_cval);
        check("mdl_cap_wrap", cap_wrap, m_cwrap);
        check("mdl_wrap_pulse", wrap_pulse, m_pulse);
        check("mdl_stable_valid", stable_valid, m_sv);
        check("mdl_stable_q", dut.w_stable_q, m_sq);
`ifdef RCC_MONOTONIC_CHECK_EN
        check("mdl_mon_err", mon_err, m_mon);
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    typedef struct {
        logic [3:0] cnt;
        logic       req;
        logic       rdy;
        int         hold;
        int         pulses;
        logic       cv;
        logic [3:0] cval;
        logic [7:0] cwrap;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int chg;
        int hold_left;
        logic [3:0] prev_sq;
        logic [3:0] base;
        tbl.push_back('{4'h0, 1'b0, 1'b0, 8, 0, 1'b0, 4'h0, 8'h0});
        for (int v = 1; v < 16; v++)
            tbl.push_back('{4'(v), 1'b0, 1'b0, 6, 0, 1'b0, 4'h0, 8'h0});
        tbl.push_back('{4'h0, 1'b0, 1'b0, 6, 1, 1'b0, 4'h0, 8'h0});
        tbl.push_back('{4'h0, 1'b1, 1'b0, 1, 0, 1'b1, 4'h0, 8'h1});
        tbl.push_back('{4'h0, 1'b0, 1'b1, 1, 0, 1'b0, 4'h0, 8'h1});

        // Reset value and first stable value latency
        cnt_in = 4'h5;
        reset = 1'b1;
        ticks(2);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_stable_valid", stable_valid, 0);
        reset = 1'b0;
        ticks(3);
        check("sv_not_yet", stable_valid, 0);
        tick();
        check("sv_after_4", stable_valid, 1);
        check("no_wrap_first", wrap_pulse, 0);
        cap_req = 1'b1;
        tick();
        check("cap5_valid", cap_valid, 1);
        check("cap5_value", cap_value, 5);
        check("cap5_wrap", cap_wrap, 0);
        cap_req = 1'b0;
        cap_ready = 1'b1;
        tick();
        check("cap5_release", cap_valid, 0);
        cap_ready = 1'b0;

        // Full count sequence with one wrap, then a snapshot
        reset = 1'b1;
        cnt_in = 4'h0;
        ticks(2);
        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            cnt_in = tbl[i].cnt;
            cap_req = tbl[i].req;
            cap_ready = tbl[i].rdy;
            pulses = 0;
            for (int c = 0; c < tbl[i].hold; c++) begin
                tick();
                pulses += int'(wrap_pulse);
            end
            check($sformatf("vec%0d_pulses", i), pulses, tbl[i].pulses);
            check($sformatf("vec%0d_cap_valid", i), cap_valid, tbl[i].cv);
            check($sformatf("vec%0d_cap_value", i), cap_value, tbl[i].cval);
            check($sformatf("vec%0d_cap_wrap", i), cap_wrap, tbl[i].cwrap);
        end
        cap_req = 1'b0;
        cap_ready = 1'b0;

        // Glitching input must not be accepted; settling updates exactly once
        cnt_in = 4'h3;
        ticks(6);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cnt_in = k[0] ? 4'h3 : 4'h4;
            tick();
            pulses += int'(wrap_pulse);
        end
        check("glitch_sq", dut.w_stable_q, 3);
        check("glitch_pulses", pulses, 0);
        cnt_in = 4'h4;
        chg = 0;
        prev_sq = dut.w_stable_q;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (dut.w_stable_q != prev_sq)
                chg++;
            prev_sq = dut.w_stable_q;
        end
        check("settle_changes", chg, 1);
        check("settle_sq", dut.w_stable_q, 4);

        // Request before any stable value waits, then holds frozen
        reset = 1'b1;
        cnt_in = 4'h2;
        ticks(2);
        reset = 1'b0;
        cap_req = 1'b1;
        tick();
        check("wait_state", dut.r_state, WAIT);
        check("wait_cap_valid", cap_valid, 0);
        cap_req = 1'b0;
        for (int k = 0; k < 20 && !cap_valid; k++)
            tick();
        check("wait_done_valid", cap_valid, 1);
        check("wait_cap_value", cap_value, 2);
        check("wait_cap_wrap", cap_wrap, 0);
        cnt_in = 4'h7;
        cap_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("frozen_valid", cap_valid, 1);
            check("frozen_value", cap_value, 2);
        end
        cap_req = 1'b0;
        cap_ready = 1'b1;
        tick();
        check("hold_release", cap_valid, 0);
        cap_ready = 1'b0;
        ticks(2);

        // Capture coincident with a wrap takes the pre-update pair
        cnt_in = 4'h1;
        ticks(3);
        cap_req = 1'b1;
        tick();
        check("coinc_valid", cap_valid, 1);
        check("coinc_value", cap_value, 7);
        check("coinc_wrap", cap_wrap, 0);
        check("coinc_pulse", wrap_pulse, 1);
        cap_req = 1'b0;
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        cap_req = 1'b1;
        tick();
        check("post_value", cap_value, 1);
        check("post_wrap", cap_wrap, 1);
        cap_req = 1'b0;

        // Reset during HOLD clears everything including the wrap count
        reset = 1'b1;
        tick();
        check("rsthold_cap_valid", cap_valid, 0);
        check("rsthold_sv", stable_valid, 0);
        check("rsthold_pulse", wrap_pulse, 0);
        reset = 1'b0;
        ticks(5);
        cap_req = 1'b1;
        tick();
        check("rsthold_value", cap_value, 1);
        check("rsthold_wrapcnt", cap_wrap, 0);
        cap_req = 1'b0;
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;

`ifdef RCC_MONOTONIC_CHECK_EN
        reset = 1'b1;
        cnt_in = 4'h3;
        ticks(2);
        reset = 1'b0;
        ticks(6);
        check("mon_first", mon_err, 0);
        cnt_in = 4'h5;
        ticks(6);
        check("mon_skip", mon_err, 1);
        cnt_in = 4'h6;
        ticks(6);
        check("mon_sticky", mon_err, 1);
`endif

        // Random stimulus against the model
        base = 4'h0;
        hold_left = 0;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            if (hold_left == 0) begin
                base = ($urandom_range(0, 3) != 0) ? 4'(base + 1) : 4'($urandom_range(0, 15));
                hold_left = $urandom_range(1, 8);
            end
            hold_left--;
            cnt_in = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : base;
            cap_req = ($urandom_range(0, 3) == 0);
            cap_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Synchronous capture stage that sits directly downstream of the 4-bit ripple carry counter. It samples the counter's asynchronous, glitch-prone outputs into the system clock domain and filters them until they are stable. It tracks counter wrap-arounds to extend the count, then hands consistent snapshots to the consumer over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default 4: width of the ripple count input.
- `SYNC_STAGES`, default 2: synchronizer flop depth (legal ≥2).
- `STABLE_CYCLES`, default 2: consecutive equal synchronized samples needed to accept a value (legal ≥1).
- `WRAP_W`, default 8: width of the wrap extension counter.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cnt_in`  in  WIDTH  raw ripple counter output; asynchronous to `clk`.
- `cap_req`  in  1  snapshot request; sampled only in IDLE.
- `cap_ready`  in  1  consumer accepts snapshot.
- `cap_valid`  out  1  snapshot held on `cap_value`/`cap_wrap`.
- `cap_value`  out  WIDTH  captured stable count.
- `cap_wrap`  out  WRAP_W  wrap count paired with `cap_value`.
- `wrap_pulse`  out  1  one-cycle pulse per detected wrap.
- `stable_valid`  out  1  at least one stable value accepted since reset.

## Operation
- Synchronizer: `cnt_in` passes through `SYNC_STAGES` flops, each bit independently.
- Stability filter: an internal run counter is compared against the last sample. Equal sample: increment (saturating). Different sample: reload 1. When the run reaches `STABLE_CYCLES`, the sample is written to `stable_q`, provided it differs from `stable_q` or `stable_valid`=0. `stable_valid` then sets and stays set until reset.
- Wrap detect: on an accepted update with `stable_valid` already 1 and new < old (unsigned):
  - `wrap_cnt` increments modulo 2^WRAP_W;
  - `wrap_pulse`=1 for exactly that cycle.
  - The first accepted value after reset never counts as a wrap.
- Capture FSM, states IDLE, WAIT, HOLD:
  - IDLE, `cap_req`=1, `stable_valid`=1: latch `stable_q`/`wrap_cnt` (their current register values, always a consistent pair) → HOLD.
  - IDLE, `cap_req`=1, `stable_valid`=0: → WAIT.
  - WAIT: on the first cycle `stable_valid`=1, latch → HOLD.
  - HOLD: `cap_valid`=1, outputs frozen. `cap_ready`=1 → IDLE.
  - `cap_req` is ignored in WAIT/HOLD. It is not queued.
- Reset, at any time including mid-handshake: FSM→IDLE. `cap_valid`, `cap_value`, `cap_wrap`, `wrap_pulse`, `stable_valid`, `wrap_cnt`, `stable_q`, and the synchronizer flops all clear to 0. The run counter clears to 0.

## Timing
- `cnt_in` change → `stable_q` update: `SYNC_STAGES`+`STABLE_CYCLES` cycles minimum (4 at defaults), provided `cnt_in` holds steady.
- `cap_req` in IDLE with `stable_valid`=1 → `cap_valid` high next cycle.
- `cap_ready` while `cap_valid`=1 → `cap_valid` low next cycle. A new `cap_req` is accepted in the cycle after that (IDLE).
- `cap_ready` while not in HOLD has no effect.
- `wrap_pulse` is asserted in the same cycle the wrapped value appears in `stable_q`.
- Capture and wrap in the same cycle: the snapshot takes the pre-update pair (old value, old wrap count).

## Configuration
- `RCC_MONOTONIC_CHECK_EN`, when defined, adds output `mon_err` (1 bit, reset 0, sticky until reset).
  - It sets on any accepted update with `stable_valid`=1 where new ≠ (old+1) mod 2^WIDTH. This flags skipped or backward counts.
- Undefined: no `mon_err` port and no check logic; behaviour is otherwise identical.

## Structure
- Shared package `rcc_pkg`: FSM state enum (IDLE, WAIT, HOLD) and default parameter constants.
- One natural sub-module, `rcc_sync_filter`: synchronizer plus stability filter. It outputs `stable_q`, `stable_valid`, and an update strobe. Wrap tracking and the FSM stay in the top.

## Test plan
- Reset, then hold `cnt_in`=4'h5 → after 4 cycles `stable_valid`=1, `stable_q`=5, no `wrap_pulse`.
- Step `cnt_in` 0→1→…→F→0, each held 6 cycles → exactly one `wrap_pulse`, `wrap_cnt`=1; a later `cap_req` returns `cap_value`=0, `cap_wrap`=1.
- Toggle `cnt_in` between 3 and 4 every cycle (glitch) → `stable_q` unchanged; on settling to 4 it updates once.
- `cap_req` before any stable value → FSM in WAIT. Then drive `cnt_in`=2 → `cap_valid`=1 with `cap_value`=2. Hold `cap_ready`=0 for 5 cycles → outputs frozen. `cap_ready`=1 → `cap_valid`=0 next cycle.
- Assert `reset` while in HOLD → next cycle `cap_valid`=0, `stable_valid`=0, `wrap_cnt`=0.
- With `RCC_MONOTONIC_CHECK_EN`: jump 3→5 → `mon_err`=1 and it stays 1; a normal 5→6 does not clear it.
